// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter: default widths,
// arbitration-mode encodings and a one-hot to index helper.
package cdb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 6;
  localparam int MAX_CH     = 8;
  localparam int IDX_W      = 3;

  localparam int ARB_FIXED  = 0;
  localparam int ARB_RR     = 1;

  // OR-reduction rather than a priority loop: input is one-hot or zero.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_CH-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-channel handshake and CDB broadcast bundle between the functional
// units (master) and the CDB arbiter (slave).
interface cdb_arbiter_if import cdb_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
);
  localparam int SRC_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]        req;
  logic [NUM_CH-1:0]        rsv;
  logic [NUM_CH-1:0]        rsv_ack;
  logic [NUM_CH-1:0]        grant;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH*TAG_W-1:0]  ch_tag;
  logic [NUM_CH-1:0]        ch_branch;
  logic [NUM_CH-1:0]        ch_branch_taken;

  logic [DATA_W-1:0]        CDB_data;
  logic [TAG_W-1:0]         CDB_tag;
  logic                     CDB_valid;
  logic                     CDB_branch;
  logic                     CDB_branch_taken;
  logic [SRC_W-1:0]         CDB_src;

  modport master (
    output req, rsv, ch_data, ch_tag, ch_branch, ch_branch_taken,
    input  rsv_ack, grant,
    input  CDB_data, CDB_tag, CDB_valid, CDB_branch, CDB_branch_taken, CDB_src
  );

  modport slave (
    input  req, rsv, ch_data, ch_tag, ch_branch, ch_branch_taken,
    output rsv_ack, grant,
    output CDB_data, CDB_tag, CDB_valid, CDB_branch, CDB_branch_taken, CDB_src
  );

endinterface

// File: rtl/cdb_arbiter_rr_priority_arbiter.sv
// Pointer-based priority arbiter; mode=0 pins the pointer to channel 0
// (fixed priority), mode=1 starts the search at ptr (round-robin).
module rr_priority_arbiter import cdb_pkg::*; #(
  parameter  int NUM_CH = 4,
  localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  input  logic              mode,
  output logic [NUM_CH-1:0] grant,
  output logic [PTR_W-1:0]  idx
);

  logic [2*NUM_CH-1:0] double_req;
  logic [2*NUM_CH-1:0] base;
  logic [2*NUM_CH-1:0] double_grant;

  // Subtracting the pointer bit from the doubled request isolates the first
  // set bit at or above ptr; the upper copy catches the wrap-around case.
  always_comb begin
    double_req   = {req, req};
    base         = (2*NUM_CH)'(1) << (mode ? ptr : '0);
    double_grant = double_req & ~(double_req - base);
    grant        = double_grant[NUM_CH-1:0] | double_grant[2*NUM_CH-1:NUM_CH];
    idx          = PTR_W'(onehot_to_idx(MAX_CH'(grant)));
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one-cycle slot reservation, policy arbitration
// and the registered CDB broadcast with branch-resolution forwarding.
module cdb_arbiter import cdb_pkg::*; #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TAG_W    = TAG_W_DEF,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);

  localparam int SRC_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [SRC_W-1:0]  rr_ptr;
  logic              rsv_q_vld;
  logic [SRC_W-1:0]  rsv_q_idx;

  logic [NUM_CH-1:0] arb_grant;
  logic [SRC_W-1:0]  arb_idx;
  logic [NUM_CH-1:0] grant;
  logic [SRC_W-1:0]  grant_idx;
  logic [NUM_CH-1:0] rsv_ack;
  logic [SRC_W-1:0]  ack_idx;
  logic              rsv_hit;

  rr_priority_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req   (bus.req),
    .ptr   (rr_ptr),
    .mode  (ARB_MODE == ARB_RR),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = arb_idx;
    rsv_ack   = '0;
    rsv_hit   = rsv_q_vld && bus.req[rsv_q_idx];
    if (reset && !flush) begin
      rsv_ack = bus.rsv & (~bus.rsv + 1'b1);
      // A reserved channel without req forfeits; normal arbitration applies.
      if (rsv_hit) begin
        grant     = NUM_CH'(1) << rsv_q_idx;
        grant_idx = rsv_q_idx;
      end else begin
        grant = arb_grant;
      end
    end
    ack_idx = SRC_W'(onehot_to_idx(MAX_CH'(rsv_ack)));
  end

  assign bus.grant   = grant;
  assign bus.rsv_ack = rsv_ack;

  // NOTE: reset is synchronous and active-low, so it is tested inside the
  // clocked block rather than appearing in the sensitivity list.
  // NOTE: all state here uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr               <= '0;
      rsv_q_vld            <= 1'b0;
      rsv_q_idx            <= '0;
      bus.CDB_data         <= '0;
      bus.CDB_tag          <= '0;
      bus.CDB_valid        <= 1'b0;
      bus.CDB_branch       <= 1'b0;
      bus.CDB_branch_taken <= 1'b0;
      bus.CDB_src          <= '0;
    end else begin
      // rsv_ack is already zero under flush, which clears the reservation.
      rsv_q_vld            <= |rsv_ack;
      rsv_q_idx            <= ack_idx;
      bus.CDB_valid        <= 1'b0;
      bus.CDB_branch       <= 1'b0;
      bus.CDB_branch_taken <= 1'b0;
      if (|grant) begin
        rr_ptr               <= (grant_idx == SRC_W'(NUM_CH-1)) ? '0 : grant_idx + SRC_W'(1);
        bus.CDB_data         <= bus.ch_data[grant_idx*DATA_W +: DATA_W];
        bus.CDB_tag          <= bus.ch_tag[grant_idx*TAG_W +: TAG_W];
        bus.CDB_src          <= grant_idx;
        bus.CDB_valid        <= ~bus.ch_branch[grant_idx];
        bus.CDB_branch       <= bus.ch_branch[grant_idx];
        bus.CDB_branch_taken <= bus.ch_branch[grant_idx] & bus.ch_branch_taken[grant_idx];
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Parametrised common-data-bus arbiter and writeback register for the Tomasulo back end.
- Arbitrates NUM_CH functional-unit result channels (int, mult, div, ld buffer, ...) onto one registered CDB per cycle.
- Selectable fixed-priority or round-robin policy.
- A channel can reserve next cycle's slot ahead of time, for fixed-latency units such as the divider.
- Carries branch-resolution results on the CDB without marking them as register writebacks.

Parameters:
- NUM_CH, 4, number of result channels (2..8).
- DATA_W, 32, result data width.
- TAG_W, 6, reservation-station tag width.
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  pipeline squash.
- req  in  NUM_CH  channel i has a result ready.
- rsv  in  NUM_CH  channel i requests a reservation of the next cycle's slot.
- rsv_ack  out  NUM_CH  reservation accepted (combinational).
- grant  out  NUM_CH  one-hot or zero; channel i owns the CDB (combinational).
- ch_data  in  NUM_CH*DATA_W  packed result data; channel i at [i*DATA_W +: DATA_W].
- ch_tag  in  NUM_CH*TAG_W  packed result tags.
- ch_branch  in  NUM_CH  result is a branch resolution.
- ch_branch_taken  in  NUM_CH  branch outcome.
- CDB_data  out  DATA_W  broadcast data.
- CDB_tag  out  TAG_W  broadcast tag.
- CDB_valid  out  1  register writeback valid.
- CDB_branch  out  1  branch resolved this cycle.
- CDB_branch_taken  out  1  resolved branch was taken.
- CDB_src  out  $clog2(NUM_CH)  index of the granted channel.

Behaviour:
- Reset (reset==0 at a clk edge):
  - All CDB_* outputs go to 0.
  - rr_ptr goes to 0.
  - Reservation register rsv_q goes to invalid.
  - grant and rsv_ack are 0 while reset is low.
- Grant, cycle t, combinational:
  - If flush: grant = 0.
  - Else if rsv_q is valid for channel r and req[r]: grant = r.
  - Else policy arbitration over req:
    - ARB_MODE 0: lowest set index.
    - ARB_MODE 1: first set index at or after rr_ptr, wrapping at NUM_CH-1 back to 0.
  - A reserved channel not raising req forfeits the slot. Normal arbitration applies that cycle and the reservation is consumed.
- Channel handshake:
  - A channel holds req, data, tag and branch stable until it sees grant in the same cycle.
  - Grant acts as a consume: the channel drops or advances req on the next cycle.
- Reservation:
  - In cycle t, rsv_ack = lowest set bit of rsv, or 0 if flush.
  - On the clk edge, rsv_q <= {ack valid, index}.
  - rsv_q is live for cycle t+1 only.
  - Losers are not queued; they re-request.
  - A channel may hold rsv_q and issue a new rsv for t+2 in the same cycle.
- Round-robin pointer:
  - On any grant to channel k, including a reserved grant, rr_ptr <= (k+1) mod NUM_CH.
  - No grant: rr_ptr holds.
  - In ARB_MODE 0 the pointer is ignored.
- CDB register, one-cycle latency (grant at t, bus at t+1):
  - Grant to k:
    - CDB_data <= data[k], CDB_tag <= tag[k], CDB_src <= k.
    - CDB_branch <= branch[k].
    - CDB_branch_taken <= branch[k] & taken[k].
    - CDB_valid <= ~branch[k].
  - No grant or flush: CDB_valid, CDB_branch and CDB_branch_taken <= 0. CDB_data, CDB_tag and CDB_src hold and are don't-care.
- Flush:
  - Kills the current grant and any new reservation.
  - Clears rsv_q on the edge.
  - A broadcast already registered (from t-1) is still presented in cycle t. Consumers gate it with their own flush.
- Reset asserted mid-operation overrides flush, pending reservations and in-flight broadcast.

Decomposition:
- Shared package cdb_pkg holds:
  - Default widths (DATA_W, TAG_W).
  - ARB_MODE encoding constants ARB_FIXED=0 and ARB_RR=1.
  - A function for one-hot to index conversion.
- One sub-module, rr_priority_arbiter:
  - Inputs: req, ptr, mode.
  - Outputs: one-hot grant and index.
  - Implemented with the double-request masking technique.
- Reservation override and the CDB register stay in the top level.

Test Plan:
- Reset low for 2 cycles with all req=1 → grant=0 and all CDB outputs 0. After release, first grant goes to channel 0 in both modes.
- ARB_MODE=1, req=4'b1111 held for 8 cycles → grants 0,1,2,3,0,1,2,3. Each CDB_tag matches the granted channel's tag one cycle later, with CDB_valid=1.
- ARB_MODE=0, req=4'b1010 for 3 cycles → grant=4'b0010 every cycle and channel 3 starved. Repeating with ARB_MODE=1 → alternation 1,3,1.
- rsv=4'b1100 at t → rsv_ack=4'b0100. At t+1 with req=4'b1111, grant=4'b0100 and rr_ptr becomes 3. At t+2 with req=4'b1111 the reservation has expired, so grant=4'b1000.
- Channel 0 granted with branch=1, taken=1, tag=6'h15 → next cycle CDB_branch=1, CDB_branch_taken=1, CDB_valid=0, CDB_tag=6'h15. A non-branch grant after it → CDB_branch=0, CDB_valid=1.
- flush=1 at t with req=4'b0001 and rsv=4'b0010 → grant=0 and rsv_ack=0 at t. At t+1 CDB_valid=0 and channel 1 is not favoured.
